// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared definitions for the arithmetic unit. It holds the
//               function-code constants and the divide-by-zero result policy.
//               Macro ARITH_DIV_EN enables the divider in arith_core.
// Revision    : 1.0  initial release
// ============================================================================
package arith_pkg;

    // Operation select codes on the func port
    localparam logic [1:0] FUNC_ADD = 2'b00;
    localparam logic [1:0] FUNC_SUB = 2'b01;
    localparam logic [1:0] FUNC_MUL = 2'b10;
    localparam logic [1:0] FUNC_DIV = 2'b11;

    // Divide by zero returns this bit replicated across the whole result,
    // which makes the result all ones and never X.
    localparam logic DIV_ZERO_FILL = 1'b1;

endpackage : arith_pkg
`default_nettype wire

// File: rtl/arith_core.sv
`default_nettype none
// ============================================================================
// Module      : arith_core
// Description : Purely combinational unsigned datapath for add, subtract,
//               multiply and (optionally) divide.
//               Macro ARITH_DIV_EN: when defined, func=11 divides;
//               when undefined, no divider is built and func=11 yields zero.
// Ports       : a, b       - WIDTH-bit unsigned operands
//               func       - 2-bit operation select
//               next_out   - WIDTH-bit result (unregistered)
//               next_carry - carry of addition, zero for other operations
// Revision    : 1.0  initial release
// ============================================================================
module arith_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       func,
    output logic [WIDTH-1:0] next_out,
    output logic             next_carry
);

    // Sum at WIDTH+1 bits so the carry falls out as the top bit
    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        next_out   = '0;
        next_carry = 1'b0;
        case (func)
            FUNC_ADD: {next_carry, next_out} = w_sum;
            // Operands and result share WIDTH, so subtraction wraps and
            // multiplication keeps only the low WIDTH bits.
            FUNC_SUB: next_out = a - b;
            FUNC_MUL: next_out = a * b;
            FUNC_DIV: begin
`ifdef ARITH_DIV_EN
                if (b == '0) begin
                    next_out = {WIDTH{DIV_ZERO_FILL}};
                end else begin
                    next_out = a / b;
                end
`else
                next_out = '0;
`endif
            end
            default: next_out = '0;
        endcase
    end

endmodule : arith_core
`default_nettype wire

// File: rtl/arith_unit.sv
`default_nettype none
// ============================================================================
// Module      : arith_unit
// Description : Registered integer arithmetic unit of the ALU datapath.
//               Wraps arith_core with output registers; one cycle latency.
//               Macro ARITH_DIV_EN (see arith_core) enables division.
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous active-high reset, clears outputs
//               a, b       - WIDTH-bit unsigned operands
//               func       - 00 add, 01 sub, 10 mul, 11 div
//               enable     - unit select; low forces zero outputs
//               arith_out  - registered result
//               carry_out  - registered carry of addition
//               arith_flag - registered "result owned by this unit"
// Revision    : 1.0  initial release
// ============================================================================
module arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       func,
    input  logic             enable,
    output logic [WIDTH-1:0] arith_out,
    output logic             carry_out,
    output logic             arith_flag
);

    logic [WIDTH-1:0] w_next_out;
    logic             w_next_carry;

    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_flag;

    arith_core #(
        .WIDTH      (WIDTH)
    ) u_core (
        .a          (a),
        .b          (b),
        .func       (func),
        .next_out   (w_next_out),
        .next_carry (w_next_carry)
    );

    // Disabled cycles clear the outputs rather than holding them, so the
    // ALU output mux never sees a stale result from this unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_carry <= 1'b0;
            r_flag  <= 1'b0;
        end else if (enable) begin
            r_out   <= w_next_out;
            r_carry <= w_next_carry;
            r_flag  <= 1'b1;
        end else begin
            r_out   <= '0;
            r_carry <= 1'b0;
            r_flag  <= 1'b0;
        end
    end

    assign arith_out  = r_out;
    assign carry_out  = r_carry;
    assign arith_flag = r_flag;

endmodule : arith_unit
`default_nettype wire

// File: tb/tb_arith_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_unit
// Description : Self-checking bench for arith_unit (WIDTH=16). Expected
//               results are pushed to a scoreboard queue as stimulus is
//               driven and compared one clock later.
//               Honours ARITH_DIV_EN the same way the design does.
// Revision    : 1.0  initial release
// ============================================================================
module tb_arith_unit;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] out;
        logic         carry;
        logic         flag;
        string        tag;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   func;
    logic         enable;
    logic [W-1:0] arith_out;
    logic         carry_out;
    logic         arith_flag;

    exp_t scoreboard[$];
    int   checks;
    int   errors;

    arith_unit #(
        .WIDTH      (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .func       (func),
        .enable     (enable),
        .arith_out  (arith_out),
        .carry_out  (carry_out),
        .arith_flag (arith_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Independent reference model using wide integer arithmetic
    function automatic exp_t model(input logic r, input logic en, input logic [1:0] f,
                                   input logic [W-1:0] x, input logic [W-1:0] y,
                                   input string tag);
        exp_t e;
        longint xl;
        longint yl;
        longint res;
        xl = longint'(x);
        yl = longint'(y);
        e.tag   = tag;
        e.out   = '0;
        e.carry = 1'b0;
        e.flag  = 1'b0;
        if (!r && en) begin
            e.flag = 1'b1;
            res = 0;
            case (f)
                2'd0: res = xl + yl;
                2'd1: res = (xl - yl + 65536) % 65536;
                2'd2: res = (xl * yl) % 65536;
                default: begin
`ifdef ARITH_DIV_EN
                    res = (yl == 0) ? 65535 : (xl / yl);
`else
                    res = 0;
`endif
                end
            endcase
            e.out   = res[W-1:0];
            e.carry = (res >= 65536) ? 1'b1 : 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle of stimulus, record the expectation, then compare
    // the outputs just after the sampling edge.
    task automatic cycle(input logic r, input logic en, input logic [1:0] f,
                         input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        exp_t e;
        @(negedge clk);
        rst    = r;
        enable = en;
        func   = f;
        a      = x;
        b      = y;
        scoreboard.push_back(model(r, en, f, x, y, tag));
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = scoreboard.pop_front();
            check({e.tag, "_out"},   32'(arith_out),  32'(e.out));
            check({e.tag, "_carry"}, 32'(carry_out),  32'(e.carry));
            check({e.tag, "_flag"},  32'(arith_flag), 32'(e.flag));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        enable = 1'b0;
        func   = 2'd0;
        a      = '0;
        b      = '0;

        // Reset dominates enable and operands
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b1, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom), "reset");
        end

        // Directed cases
        cycle(1'b0, 1'b1, 2'd0, 16'hFFFF, 16'h0001, "add_carry");
        cycle(1'b0, 1'b1, 2'd0, 16'd100,  16'd23,   "add_plain");
        cycle(1'b0, 1'b1, 2'd1, 16'd5,    16'd7,    "sub_wrap");
        cycle(1'b0, 1'b1, 2'd1, 16'd7,    16'd5,    "sub_plain");
        cycle(1'b0, 1'b1, 2'd2, 16'h0100, 16'h0101, "mul_trunc");
        cycle(1'b0, 1'b1, 2'd2, 16'hFFFF, 16'hFFFF, "mul_max");
        cycle(1'b0, 1'b1, 2'd3, 16'd1000, 16'd7,    "div_plain");
        cycle(1'b0, 1'b1, 2'd3, 16'd1234, 16'd0,    "div_zero");
        cycle(1'b0, 1'b1, 2'd3, 16'd5,    16'd9,    "div_small");
        cycle(1'b0, 1'b1, 2'd0, 16'h8000, 16'h8000, "add_half");

        // Random back-to-back traffic, occasionally with b=0
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] rb;
            rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), W'($urandom), rb, "random");
        end

        // Disable clears outputs rather than holding them
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), W'($urandom), W'($urandom), "disabled");
        end

        // Reset mid-stream, then recovery
        cycle(1'b0, 1'b1, 2'd0, 16'hFFFF, 16'h0002, "pre_rst");
        cycle(1'b1, 1'b1, 2'd0, 16'hFFFF, 16'h0002, "mid_rst");
        cycle(1'b0, 1'b1, 2'd2, 16'd300,  16'd3,    "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_arith_unit
`default_nettype wire
